input_port_buffer: RTL
======================

INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO depth in flits, a power of 2 and at least 2.
REQ-002 SHALL have parameter ROUTER_ADDR, default 2'b01: own mesh address, where bit0 is X and bit1 is Y.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_flit, input, 32 bits: incoming flit.
- [31:29] is the flit type: HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100.
- In a header, [28:17] is the packet length and [1:0] is the destination address.
REQ-006 SHALL have port in_valid, input, 1 bit: in_flit is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the buffer accepts a flit this cycle.
REQ-008 SHALL have port out_flit, output, 32 bits: the flit at the FIFO head.
REQ-009 SHALL have port flit_type, output, 3 bits: type field of the head flit, or 0 when the FIFO is empty.
REQ-010 SHALL have port length, output, 12 bits: packet length for the arbiter timer.
REQ-011 SHALL have port req, output, 5 bits: one-hot request, bit order {L,N,E,S,W} = [4:0].
REQ-012 SHALL have port grant, input, 1 bit: downstream consumes the head flit this cycle.
REQ-013 SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-014 SHALL push when in_valid && in_ready; in_ready = !full.
REQ-015 SHALL pop when grant && (req != 0); a grant with req==0 SHALL be ignored.
REQ-016 SHALL make a pushed flit visible at the head no earlier than the next cycle; an empty FIFO provides no bypass path.
REQ-017 SHALL maintain an occupancy count of 0..DEPTH and wrap the read and write pointers modulo DEPTH.
REQ-018 SHALL apply push and pop together in the same cycle, leaving the count unchanged.
REQ-019 SHALL never push while full, even when a pop occurs in the same cycle, because in_ready is registered-state based.
REQ-020 SHALL implement a two-state FSM.
- IDLE: wait for a HEADER at the head.
- ROUTED: a packet is in progress.
REQ-021 SHALL, in IDLE with a HEADER at the head, compute the route combinationally using XY routing.
- X first: dest X > own X gives E, dest X < own X gives W.
- Then Y: dest Y > own Y gives S, dest Y < own Y gives N.
- Equal address gives L.
REQ-022 SHALL, in IDLE with a HEADER at the head, drive req with that route in the same cycle, and latch route and length when that header pops.
REQ-023 SHALL move IDLE to ROUTED on a header pop, unless the header is also the packet's TAIL.
REQ-024 SHALL, in ROUTED, drive req with the latched route whenever the FIFO is non-empty, and 0 when it is empty.
REQ-025 SHALL move ROUTED to IDLE on a TAIL pop.
REQ-026 SHALL drive length from the head flit's [28:17] when the head is a HEADER, and otherwise from the latched length.
REQ-027 SHALL, in IDLE, auto-pop a non-HEADER flit at the head in one cycle with req=0, and set err.
REQ-028 SHALL, in ROUTED, treat a HEADER at the head as an error: set err, force ROUTED to IDLE without popping, and route the flit on the next cycle.

Reset
REQ-029 SHALL, while rst is low, force the following immediately and asynchronously:
- count=0, pointers=0, FSM=IDLE;
- in_ready=1, req=0, flit_type=0, length=0, out_flit=0, err=0.
REQ-030 SHALL discard a packet that is in flight when reset asserts; after release, the first non-HEADER flit SHALL be treated per REQ-027.

Configuration
REQ-031 SHALL, when macro INPUT_PORT_STATS_EN is defined, add an output pkt_count of 16 bits.
- It increments on each TAIL pop and wraps from 16'hFFFF to 0.
- Reset value is 0.
REQ-032 SHALL, when INPUT_PORT_STATS_EN is undefined, omit the pkt_count port and its counter; all other behaviour is identical.

Verification
REQ-033 SHALL cover local packet routing.
- Stimulus: ROUTER_ADDR=01; push HEADER dest=01 len=3, then PAYLOAD, then TAIL; hold grant=1.
- Response: req=5'b10000 for 3 cycles; length=3 on the header cycle; FSM back in IDLE.
REQ-034 SHALL cover X-first routing.
- Stimulus: push HEADER dest=10.
- Response: req=5'b00001 (W), because X is resolved before Y.
REQ-035 SHALL cover full-FIFO back-pressure.
- Stimulus: push 4 flits with grant=0.
- Response: in_ready=0 and the 5th flit is not accepted.
- Then grant=1 for 1 cycle: in_ready=1 on the following cycle.
REQ-036 SHALL cover mid-packet starvation.
- Stimulus: HEADER dest=00 popped, then the FIFO runs empty.
- Response: req=0 while empty; req=5'b00001 returns when the TAIL arrives; route unchanged.
REQ-037 SHALL cover the orphan flit.
- Stimulus: PAYLOAD pushed in IDLE.
- Response: it drops in 1 cycle, err=1, req=0.
- Then a reset pulse: err=0 and all outputs at reset values while rst is low.
REQ-038 SHALL cover the statistics counter with INPUT_PORT_STATS_EN defined.
- Stimulus: 3 complete packets.
- Response: pkt_count=3.

Source files
------------

// File: rtl/input_port_buffer.sv
// Mesh router input port: flit FIFO with XY route computation and packet FSM.
// Optional INPUT_PORT_STATS_EN adds a 16-bit count of TAIL flits popped.
module input_port_buffer #(
    parameter int         DEPTH       = 4,
    parameter logic [1:0] ROUTER_ADDR = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_flit,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_flit,
    output logic [2:0]  flit_type,
    output logic [11:0] length,
    output logic [4:0]  req,
    input  logic        grant,
`ifdef INPUT_PORT_STATS_EN
    output logic [15:0] pkt_count,
`endif
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, ROUTED} state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    state_t        state;
    state_t        next_state;
    logic [4:0]    rt_q;
    logic [11:0]   len_q;
    logic [4:0]    route;
    logic [31:0]   head;
    logic          empty;
    logic          full;
    logic          is_hdr;
    logic          is_tail;
    logic          push;
    logic          pop;
    logic          take_hdr;
    logic          set_err;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign head      = empty ? 32'd0 : mem[rd_ptr];
    assign is_hdr    = head[29];
    assign is_tail   = head[31];
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign out_flit  = head;
    assign flit_type = head[31:29];
    assign length    = is_hdr ? head[28:17] : len_q;

    // XY route of the head header: X resolved first, then Y, else local.
    always_comb begin
        route = 5'b10000;
        if (head[0] > ROUTER_ADDR[0])
            route = 5'b00100;
        else if (head[0] < ROUTER_ADDR[0])
            route = 5'b00001;
        else if (head[1] > ROUTER_ADDR[1])
            route = 5'b00010;
        else if (head[1] < ROUTER_ADDR[1])
            route = 5'b01000;
    end

    // Packet FSM: request generation, pop decision and error detection.
    always_comb begin
        next_state = state;
        req        = 5'b00000;
        pop        = 1'b0;
        take_hdr   = 1'b0;
        set_err    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    if (is_hdr) begin
                        req = route;
                        if (grant) begin
                            pop      = 1'b1;
                            take_hdr = 1'b1;
                            if (!is_tail)
                                next_state = ROUTED;
                        end
                    end else begin
                        // Orphan flit outside a packet is dropped.
                        pop     = 1'b1;
                        set_err = 1'b1;
                    end
                end
            end
            ROUTED: begin
                if (!empty) begin
                    if (is_hdr) begin
                        // New header mid-packet: abandon packet, keep header.
                        set_err    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        req = rt_q;
                        if (grant) begin
                            pop = 1'b1;
                            if (is_tail)
                                next_state = IDLE;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FIFO storage; contents are masked by the count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_flit;
    end

    // Pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state, latched route/length and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rt_q  <= '0;
            len_q <= '0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            if (take_hdr) begin
                rt_q  <= route;
                len_q <= head[28:17];
            end
            if (set_err)
                err <= 1'b1;
        end
    end

`ifdef INPUT_PORT_STATS_EN
    // Completed-packet counter, one step per TAIL leaving the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pkt_count <= '0;
        else if (pop && is_tail)
            pkt_count <= pkt_count + 16'd1;
    end
`endif

endmodule
